// File: rtl/gray_codec_pkg.sv
// Shared definitions for the streaming binary/Gray converter.
// Conversion helpers work on a 32-bit container masked to the live width.
package gray_codec_pkg;

   localparam int  MAX_W    = 32;
   localparam logic MODE_B2G = 1'b0;
   localparam logic MODE_G2B = 1'b1;

   function automatic logic [MAX_W-1:0] width_mask(input int w);
      if (w >= MAX_W)
         return '1;
      return (32'd1 << w) - 32'd1;
   endfunction

   function automatic logic [MAX_W-1:0] bin2gray(
      input logic [MAX_W-1:0] b,
      input int               w
   );
      logic [MAX_W-1:0] m;
      m = b & width_mask(w);
      return m ^ (m >> 1);
   endfunction

   // Prefix XOR from the MSB down; bits at or above w stay zero.
   function automatic logic [MAX_W-1:0] gray2bin(
      input logic [MAX_W-1:0] g,
      input int               w
   );
      logic [MAX_W-1:0] r;
      logic             acc;
      r   = '0;
      acc = 1'b0;
      for (int i = MAX_W - 1; i >= 0; i--) begin
         if (i < w) begin
            acc  = acc ^ g[i];
            r[i] = acc;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/gray_codec_stage.sv
// One pipeline register holding valid, mode and data.
// Payload only moves when the incoming beat is valid.
module gray_codec_stage
   import gray_codec_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic             i_valid,
   input  logic             i_mode,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   output logic             o_mode,
   output logic [WIDTH-1:0] o_data
);

   logic             r_valid;
   logic             r_mode;
   logic [WIDTH-1:0] r_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_mode  <= MODE_B2G;
         r_data  <= '0;
      end else if (i_load) begin
         r_valid <= i_valid;
         if (i_valid) begin
            r_mode <= i_mode;
            r_data <= i_data;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_mode  = r_mode;
   assign o_data  = r_data;

endmodule

// File: rtl/gray_codec_pipe.sv
// Stallable binary<->Gray converter: convert on entry, then STAGES
// registers with a combinational ready chain back from out_ready.
module gray_codec_pipe
   import gray_codec_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_mode,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_mode
);

   logic [WIDTH-1:0] w_conv;
   logic [STAGES:0]  w_valid;
   logic [STAGES:0]  w_mode;
   logic [STAGES-1:0] w_load;
   logic [WIDTH-1:0] w_data [STAGES+1];

   assign w_conv = (in_mode == MODE_G2B)
                 ? WIDTH'(gray2bin(32'(in_data), WIDTH))
                 : WIDTH'(bin2gray(32'(in_data), WIDTH));

   assign w_valid[0] = in_valid;
   assign w_mode[0]  = in_mode;
   assign w_data[0]  = w_conv;

   // Stage k loads when it is empty or its successor takes its beat.
   always_comb begin
      w_load = '0;
      w_load[STAGES-1] = !w_valid[STAGES] | out_ready;
      for (int k = STAGES - 2; k >= 0; k--)
         w_load[k] = !w_valid[k+1] | w_load[k+1];
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      gray_codec_stage #(
         .WIDTH (WIDTH)
      ) u_stage (
         .clk     (clk),
         .rst_n   (rst_n),
         .i_load  (w_load[k]),
         .i_valid (w_valid[k]),
         .i_mode  (w_mode[k]),
         .i_data  (w_data[k]),
         .o_valid (w_valid[k+1]),
         .o_mode  (w_mode[k+1]),
         .o_data  (w_data[k+1])
      );
   end

   assign in_ready  = w_load[0];
   assign out_valid = w_valid[STAGES];
   assign out_mode  = w_mode[STAGES];
   assign out_data  = w_data[STAGES];

endmodule

// File: tb/tb_gray_codec_pipe.sv
// Directed bench for gray_codec_pipe in three configurations:
// W4/S2, W8/S3 and W1/S1, sharing one clock and reset.
module tb_gray_codec_pipe;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   logic       c4_in_valid = 0, c4_in_ready, c4_in_mode = 0;
   logic [3:0] c4_in_data = 0, c4_out_data;
   logic       c4_out_valid, c4_out_ready = 1, c4_out_mode;

   logic       c8_in_valid = 0, c8_in_ready, c8_in_mode = 0;
   logic [7:0] c8_in_data = 0, c8_out_data;
   logic       c8_out_valid, c8_out_ready = 1, c8_out_mode;

   logic       c1_in_valid = 0, c1_in_ready, c1_in_mode = 0;
   logic [0:0] c1_in_data = 0, c1_out_data;
   logic       c1_out_valid, c1_out_ready = 1, c1_out_mode;

   gray_codec_pipe #(.WIDTH(4), .STAGES(2)) u_c4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(c4_in_valid), .in_ready(c4_in_ready),
      .in_mode(c4_in_mode), .in_data(c4_in_data),
      .out_valid(c4_out_valid), .out_ready(c4_out_ready),
      .out_data(c4_out_data), .out_mode(c4_out_mode)
   );

   gray_codec_pipe #(.WIDTH(8), .STAGES(3)) u_c8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(c8_in_valid), .in_ready(c8_in_ready),
      .in_mode(c8_in_mode), .in_data(c8_in_data),
      .out_valid(c8_out_valid), .out_ready(c8_out_ready),
      .out_data(c8_out_data), .out_mode(c8_out_mode)
   );

   gray_codec_pipe #(.WIDTH(1), .STAGES(1)) u_c1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(c1_in_valid), .in_ready(c1_in_ready),
      .in_mode(c1_in_mode), .in_data(c1_in_data),
      .out_valid(c1_out_valid), .out_ready(c1_out_ready),
      .out_data(c1_out_data), .out_mode(c1_out_mode)
   );

   // 4-bit reference model, written independently of the RTL helpers
   function automatic logic [3:0] ref4(input logic [3:0] d, input logic m);
      logic [3:0] b;
      if (!m)
         return d ^ (d >> 1);
      b = d;
      b = b ^ (b >> 1);
      b = b ^ (b >> 2);
      return b;
   endfunction

   logic [3:0] q_in_d[$];
   logic       q_in_m[$];
   logic [3:0] q_out_d[$];
   logic       q_out_m[$];
   int         q_out_cyc[$];
   int         q_acc_cyc[$];

   // Streams q_in_* through u_c4 and records what comes out
   task automatic run4(input bit rnd, input int maxcyc);
      int idx = 0;
      int cyc = 0;
      q_out_d.delete(); q_out_m.delete();
      q_out_cyc.delete(); q_acc_cyc.delete();
      while (cyc < maxcyc && q_out_d.size() < q_in_d.size()) begin
         c4_in_valid = (idx < q_in_d.size()) &&
                       (!rnd || $urandom_range(0, 3) != 0);
         if (idx < q_in_d.size()) begin
            c4_in_data = q_in_d[idx];
            c4_in_mode = q_in_m[idx];
         end
         c4_out_ready = !rnd || ($urandom_range(0, 2) != 0);
         @(negedge clk);
         if (c4_in_valid && c4_in_ready) begin
            q_acc_cyc.push_back(cyc);
            idx++;
         end
         if (c4_out_valid && c4_out_ready) begin
            q_out_d.push_back(c4_out_data);
            q_out_m.push_back(c4_out_mode);
            q_out_cyc.push_back(cyc);
         end
         @(posedge clk); #1;
         cyc++;
      end
      c4_in_valid = 0;
      c4_out_ready = 1;
      total++;
      if (q_out_d.size() != q_in_d.size()) begin
         bad++;
         $display("FAIL run4_timeout got=%0d beats want=%0d",
                  q_out_d.size(), q_in_d.size());
      end
   endtask

   task automatic test_reset();
      #3;
      total++;
      if ({c4_out_valid, c8_out_valid, c1_out_valid} !== 3'b000) begin
         bad++;
         $display("FAIL reset_valid got=%b want=000",
                  {c4_out_valid, c8_out_valid, c1_out_valid});
      end
      total++;
      if ({c4_out_data, c8_out_data, c1_out_data} !== 13'd0) begin
         bad++;
         $display("FAIL reset_data got=%h want=0",
                  {c4_out_data, c8_out_data, c1_out_data});
      end
      total++;
      if ({c4_out_mode, c8_out_mode, c1_out_mode} !== 3'b000) begin
         bad++;
         $display("FAIL reset_mode got=%b want=000",
                  {c4_out_mode, c8_out_mode, c1_out_mode});
      end
      @(posedge clk); #1;
      rst_n = 1;
      @(negedge clk);
      total++;
      if ({c4_in_ready, c8_in_ready, c1_in_ready} !== 3'b111) begin
         bad++;
         $display("FAIL reset_in_ready got=%b want=111",
                  {c4_in_ready, c8_in_ready, c1_in_ready});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_b2g_sweep();
      logic [3:0] exp [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7,
                               4'h5, 4'h4, 4'hC, 4'hD, 4'hF, 4'hE,
                               4'hA, 4'hB, 4'h9, 4'h8};
      q_in_d.delete(); q_in_m.delete();
      for (int i = 0; i < 16; i++) begin
         q_in_d.push_back(4'(i));
         q_in_m.push_back(1'b0);
      end
      run4(0, 60);
      for (int i = 0; i < q_out_d.size(); i++) begin
         total++;
         if (q_out_d[i] !== exp[i]) begin
            bad++;
            $display("FAIL b2g_sweep[%0d] got=%h want=%h",
                     i, q_out_d[i], exp[i]);
         end
      end
      if (q_out_d.size() == 16) begin
         total++;
         if (q_out_cyc[0] - q_acc_cyc[0] != 2) begin
            bad++;
            $display("FAIL b2g_latency got=%0d want=2",
                     q_out_cyc[0] - q_acc_cyc[0]);
         end
         total++;
         if (q_out_cyc[15] - q_out_cyc[0] != 15) begin
            bad++;
            $display("FAIL b2g_throughput got=%0d want=15",
                     q_out_cyc[15] - q_out_cyc[0]);
         end
      end
   endtask

   task automatic test_g2b_interleave();
      logic [3:0] gin [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7,
                               4'h5, 4'h4, 4'hC, 4'hD, 4'hF, 4'hE,
                               4'hA, 4'hB, 4'h9, 4'h8};
      logic [3:0] mix_d [6] = '{4'h5, 4'h5, 4'hC, 4'hC, 4'h9, 4'h9};
      logic       mix_m [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [3:0] mix_e [6] = '{4'h7, 4'h6, 4'hA, 4'h8, 4'hD, 4'hE};
      q_in_d.delete(); q_in_m.delete();
      for (int i = 0; i < 16; i++) begin
         q_in_d.push_back(gin[i]);
         q_in_m.push_back(1'b1);
      end
      run4(0, 60);
      for (int i = 0; i < q_out_d.size(); i++) begin
         total++;
         if (q_out_d[i] !== 4'(i) || q_out_m[i] !== 1'b1) begin
            bad++;
            $display("FAIL g2b_sweep[%0d] got=%h/%b want=%h/1",
                     i, q_out_d[i], q_out_m[i], 4'(i));
         end
      end
      q_in_d.delete(); q_in_m.delete();
      for (int i = 0; i < 6; i++) begin
         q_in_d.push_back(mix_d[i]);
         q_in_m.push_back(mix_m[i]);
      end
      run4(0, 40);
      for (int i = 0; i < q_out_d.size(); i++) begin
         total++;
         if (q_out_d[i] !== mix_e[i] || q_out_m[i] !== mix_m[i]) begin
            bad++;
            $display("FAIL interleave[%0d] got=%h/%b want=%h/%b",
                     i, q_out_d[i], q_out_m[i], mix_e[i], mix_m[i]);
         end
      end
   endtask

   task automatic test_w8_s3();
      logic [7:0] din [4] = '{8'hA5, 8'hF7, 8'hFF, 8'h80};
      logic       dm  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [7:0] exp [4] = '{8'hF7, 8'hA5, 8'h80, 8'hFF};
      int acc [4];
      int idx = 0;
      int oc = 0;
      c8_out_ready = 1;
      for (int cyc = 0; cyc < 20 && oc < 4; cyc++) begin
         c8_in_valid = idx < 4;
         if (idx < 4) begin
            c8_in_data = din[idx];
            c8_in_mode = dm[idx];
         end
         @(negedge clk);
         if (c8_in_valid && c8_in_ready) begin
            acc[idx] = cyc;
            idx++;
         end
         if (c8_out_valid) begin
            total++;
            if (c8_out_data !== exp[oc] || c8_out_mode !== dm[oc] ||
                cyc - acc[oc] != 3) begin
               bad++;
               $display("FAIL w8[%0d] got=%h/%b lat=%0d want=%h/%b lat=3",
                        oc, c8_out_data, c8_out_mode, cyc - acc[oc],
                        exp[oc], dm[oc]);
            end
            oc++;
         end
         @(posedge clk); #1;
      end
      c8_in_valid = 0;
      total++;
      if (oc != 4) begin
         bad++;
         $display("FAIL w8_count got=%0d want=4", oc);
      end
   endtask

   task automatic test_backpressure();
      logic [3:0] din [6] = '{4'h3, 4'h5, 4'h9, 4'hA, 4'hE, 4'h1};
      logic [3:0] exp [6] = '{4'h2, 4'h7, 4'hD, 4'hF, 4'h9, 4'h1};
      int idx = 0;
      int oc = 0;
      c4_in_mode = 0;
      for (int cyc = 0; cyc < 30 && oc < 6; cyc++) begin
         c4_in_valid = idx < 6;
         if (idx < 6)
            c4_in_data = din[idx];
         c4_out_ready = cyc >= 6;
         @(negedge clk);
         if (c4_in_valid && c4_in_ready)
            idx++;
         if (cyc >= 2 && cyc < 6) begin
            total++;
            if (c4_out_valid !== 1'b1 || c4_out_data !== 4'h2) begin
               bad++;
               $display("FAIL bp_stable cyc=%0d got=%b/%h want=1/2",
                        cyc, c4_out_valid, c4_out_data);
            end
         end
         if (cyc == 5) begin
            total++;
            if (idx != 2 || c4_in_ready !== 1'b0) begin
               bad++;
               $display("FAIL bp_capacity got=%0d/%b want=2/0",
                        idx, c4_in_ready);
            end
         end
         if (c4_out_valid && c4_out_ready) begin
            total++;
            if (c4_out_data !== exp[oc]) begin
               bad++;
               $display("FAIL bp_order[%0d] got=%h want=%h",
                        oc, c4_out_data, exp[oc]);
            end
            oc++;
         end
         @(posedge clk); #1;
      end
      c4_in_valid = 0;
      c4_out_ready = 1;
      total++;
      if (oc != 6) begin
         bad++;
         $display("FAIL bp_count got=%0d want=6", oc);
      end
   endtask

   task automatic test_random_bp();
      int errs = 0;
      q_in_d.delete(); q_in_m.delete();
      for (int i = 0; i < 1000; i++) begin
         q_in_d.push_back(4'($urandom_range(0, 15)));
         q_in_m.push_back(1'($urandom_range(0, 1)));
      end
      run4(1, 8000);
      for (int i = 0; i < q_out_d.size(); i++) begin
         if (q_out_d[i] !== ref4(q_in_d[i], q_in_m[i]) ||
             q_out_m[i] !== q_in_m[i])
            errs++;
      end
      total++;
      if (errs != 0) begin
         bad++;
         $display("FAIL random_bp got=%0d bad beats want=0", errs);
      end
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      int ocyc = -1;
      c4_out_ready = 0;
      c4_in_mode = 0;
      for (int i = 0; i < 2; i++) begin
         c4_in_valid = 1;
         c4_in_data = 4'(i + 7);
         @(posedge clk); #1;
      end
      c4_in_valid = 0;
      total++;
      if (c4_out_valid !== 1'b1) begin
         bad++;
         $display("FAIL rst_mid_pre got=%b want=1", c4_out_valid);
      end
      #1 rst_n = 0;
      #1;
      total++;
      if (c4_out_valid !== 1'b0 || c4_out_data !== 4'h0) begin
         bad++;
         $display("FAIL rst_mid_async got=%b/%h want=0/0",
                  c4_out_valid, c4_out_data);
      end
      @(posedge clk); #1;
      rst_n = 1;
      @(negedge clk);
      total++;
      if (c4_in_ready !== 1'b1) begin
         bad++;
         $display("FAIL rst_mid_ready got=%b want=1", c4_in_ready);
      end
      @(posedge clk); #1;
      c4_out_ready = 1;
      for (int cyc = 0; cyc < 8; cyc++) begin
         c4_in_valid = cyc == 0;
         c4_in_data = 4'h6;
         @(negedge clk);
         if (c4_out_valid) begin
            seen++;
            ocyc = cyc;
            total++;
            if (c4_out_data !== 4'h5) begin
               bad++;
               $display("FAIL rst_mid_data got=%h want=5", c4_out_data);
            end
         end
         @(posedge clk); #1;
      end
      c4_in_valid = 0;
      total++;
      if (seen != 1 || ocyc != 2) begin
         bad++;
         $display("FAIL rst_mid_after got=%0d beats at %0d want=1 at 2",
                  seen, ocyc);
      end
   endtask

   task automatic test_w1_s1();
      logic din [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic dm  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      int acc [4];
      int idx = 0;
      int oc = 0;
      c1_out_ready = 1;
      for (int cyc = 0; cyc < 12 && oc < 4; cyc++) begin
         c1_in_valid = idx < 4;
         if (idx < 4) begin
            c1_in_data = din[idx];
            c1_in_mode = dm[idx];
         end
         @(negedge clk);
         if (c1_in_valid && c1_in_ready) begin
            acc[idx] = cyc;
            idx++;
         end
         if (c1_out_valid) begin
            total++;
            if (c1_out_data[0] !== din[oc] || c1_out_mode !== dm[oc] ||
                cyc - acc[oc] != 1) begin
               bad++;
               $display("FAIL w1[%0d] got=%b/%b lat=%0d want=%b/%b lat=1",
                        oc, c1_out_data, c1_out_mode, cyc - acc[oc],
                        din[oc], dm[oc]);
            end
            oc++;
         end
         @(posedge clk); #1;
      end
      c1_in_valid = 0;
      total++;
      if (oc != 4) begin
         bad++;
         $display("FAIL w1_count got=%0d want=4", oc);
      end
   endtask

   initial begin
      test_reset();
      test_b2g_sweep();
      test_g2b_interleave();
      test_w8_s3();
      test_backpressure();
      test_random_bp();
      test_reset_mid();
      test_w1_s1();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gray_codec_pipe.md
Name: gray_codec_pipe

Overview:
Parametrised streaming binary/Gray converter. It succeeds the fixed 4-bit combinational binary-to-Gray block.
- Generalised to WIDTH bits.
- Per-beat direction select: binary->Gray or Gray->binary.
- STAGES registered pipeline with valid/ready handshake and full backpressure.
- Used ahead of CDC pointer logic and encoder datapaths that need a throughput-1, stallable converter.

Parameters:
WIDTH, 8, data width in bits; legal 1..32
STAGES, 2, number of registered pipeline stages; legal 1..4

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat present
in_ready  out  1  block can accept input this cycle
in_mode  in  1  0 = binary->Gray, 1 = Gray->binary
in_data  in  WIDTH  value to convert
out_valid  out  1  output beat present
out_ready  in  1  downstream accepts output this cycle
out_data  out  WIDTH  converted value
out_mode  out  1  in_mode echoed with its beat

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-low (rst_n).
  - While rst_n=0, all stage valid bits clear, so out_valid=0.
  - out_data=0 and out_mode=0.
  - in_ready=1 as soon as reset deasserts.
- Conversion is computed combinationally from in_data and in_mode, then captured into stage 1. Stages 2..STAGES carry data, mode and valid only.
- Binary->Gray: g = b XOR (b >> 1).
- Gray->binary: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] XOR g[i] for i = WIDTH-2 down to 0. Prefix XOR, no carries.
- WIDTH=1: both directions are identity.
- Handshake:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - out_valid, out_data and out_mode must remain stable while out_valid=1 and out_ready=0.
- Stage advance rule: stage k loads from stage k-1 when (stage k empty) OR (stage k drains this cycle).
  - The last stage drains when out_ready=1.
  - in_ready = stage-1 load enable. This is a combinational ready chain from out_ready; no extra register.
  - Stages do not load data when their source is invalid; only the valid bit clears.
- Latency: exactly STAGES cycles from input transfer to out_valid with out_ready held 1.
- Throughput: 1 beat/cycle sustained.
- Capacity: STAGES beats.
  - With out_ready=0, exactly STAGES beats are accepted, then in_ready=0.
  - Bubbles collapse: an empty intermediate stage is filled even while the output is stalled.
- Simultaneous fill and drain on a full pipe: in_ready=1 and all stages shift in the same cycle. No beat is lost or duplicated.
- Ordering: strict FIFO, modes may interleave per beat.
- Reset mid-operation: all in-flight beats are discarded. out_valid drops asynchronously on rst_n falling edge.
- in_valid is not required to stay asserted after a refused beat. Dropping it is legal (no protocol check).
- No overflow or error states; the block is lossless by construction.

Decomposition:
- Package gray_codec_pkg:
  - MODE_B2G=1'b0, MODE_G2B=1'b1.
  - Functions bin2gray(WIDTH) and gray2bin(WIDTH), parameterised via a fixed max width of 32 with masking.
- Sub-module gray_codec_stage: one register stage holding valid, mode and data, with load/drain logic. It is instantiated STAGES times in a generate loop. The top holds the conversion function call and the handshake chain.

Test Plan:
1. WIDTH=4, STAGES=2, out_ready=1, mode 0, sweep in_data 0..15 back-to-back:
   - out_data sequence 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8.
   - First out_valid 2 cycles after first accept; 16 consecutive output cycles.
2. WIDTH=4, mode 1, sweep Gray inputs 0,1,3,2,...,8 -> out_data 0..15 in order. Interleaving modes per beat preserves each beat's out_mode.
3. WIDTH=8, STAGES=3:
   - 0xA5 mode 0 -> 0xF7.
   - 0xF7 mode 1 -> 0xA5.
   - 0xFF mode 0 -> 0x80.
   - 0x80 mode 1 -> 0xFF.
   - All appear after 3 cycles.
4. Backpressure, STAGES=2: hold out_ready=0 with in_valid=1 for 6 cycles.
   - Exactly 2 beats accepted, then in_ready=0.
   - out_data stays stable.
   - Raise out_ready: full rate resumes, order intact, no duplicates.
   - Randomized out_ready for 1000 beats matches a reference model.
5. Reset mid-stream: assert rst_n=0 with 2 beats in flight.
   - out_valid=0 immediately (asynchronous), out_data=0.
   - After release, in_ready=1 and the next beat emerges STAGES cycles later with no stale data.
6. WIDTH=1, STAGES=1: inputs 0,1 in both modes -> out_data equals in_data, latency 1.
